dma_copy_engine: RTL

Memory-to-memory block-copy engine that drives the DMA request port of the memory controller, the lowest-priority requester behind CPU and accelerator. Software programs source, destination and word count, then pulses `start`. The engine issues alternating single-word reads and writes, one outstanding access at a time, and waits for `mem_valid` before each next step. It reports completion, abort and timeout status.

---
 rtl/dma_copy_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dma_copy_engine.sv
// Single-outstanding memory-to-memory copy engine for the memory controller's DMA port.
// Reads one word, writes it, and repeats until len words are copied, aborted, or timed out.
module dma_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  xfer_count,
  output logic                  mem_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d, count_inc;
  logic [WAIT_W-1:0]     wait_q, wait_d, wait_inc;
  logic                  error_q, error_d;
  logic                  aborted_q, aborted_d;
  logic                  stop;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    count_d   = count_q;
    wait_d    = '0;
    error_d   = error_q;
    aborted_d = aborted_q;
    wait_inc  = wait_q + WAIT_W'(1);
    count_inc = count_q + LEN_WIDTH'(1);
    // An abort seen at any point of an access ends the transfer once that access completes.
    stop      = aborted_q | abort;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_d     = src_addr;
          dst_d     = dst_addr;
          len_d     = len;
          count_d   = '0;
          error_d   = 1'b0;
          aborted_d = 1'b0;
          state_d   = (len == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ: begin
        aborted_d = stop;
        state_d   = RD_WAIT;
      end
      RD_WAIT: begin
        aborted_d = stop;
        if (mem_valid) begin
          state_d = stop ? FINISH : WR_REQ;
        end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          wait_d = wait_inc;
        end
      end
      WR_REQ: begin
        aborted_d = stop;
        state_d   = WR_WAIT;
      end
      WR_WAIT: begin
        aborted_d = stop;
        if (mem_valid) begin
          count_d = count_inc;
          state_d = (stop || count_inc == len_q) ? FINISH : RD_REQ;
        end else if (wait_inc == WAIT_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          wait_d = wait_inc;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so each one lines up with its state cycle.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FINISH);
    mem_en_d    = (state_d == RD_REQ) || (state_d == WR_REQ);
    mem_wr_en_d = (state_d == WR_REQ);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d == RD_REQ) begin
      mem_addr_d = src_d + ADDR_WIDTH'(count_d);
    end else if (state_d == WR_REQ) begin
      mem_addr_d  = dst_d + ADDR_WIDTH'(count_d);
      mem_wdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      count_q     <= '0;
      wait_q      <= '0;
      error_q     <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      count_q     <= count_d;
      wait_q      <= wait_d;
      error_q     <= error_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign aborted    = aborted_q;
  assign xfer_count = count_q;
  assign mem_en     = mem_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
